// File: rtl/reg_pkg.sv
// reg_pkg: shared widths and sequencer state encoding for the register-file slice.
package reg_pkg;
  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  typedef enum logic [2:0] {IDLE, SEED0, SEED1, STEP, FIN} state_t;
endpackage

// File: rtl/add_w.sv
// add_w: W-bit adder returning {carry, sum}.
module add_w #(
  parameter int W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [W:0]   s
);
  assign s = {1'b0, x} + {1'b0, y};
endmodule

// File: rtl/reg_fib_seq.sv
// reg_fib_seq: seeds reg[0..1] then fills the register file with reg[k] = reg[k-2] + reg[k-1].
module reg_fib_seq
  import reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed0,
  input  logic [DATA_W-1:0] seed1,
  output logic [ADDR_W-1:0] ra0,
  output logic [ADDR_W-1:0] ra1,
  input  logic [DATA_W-1:0] rd0,
  input  logic [DATA_W-1:0] rd1,
  output logic [ADDR_W-1:0] wa,
  output logic [DATA_W-1:0] wd,
  output logic              we,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] c,
  output logic              valid,
  output logic              busy,
  output logic              done,
  output logic              ovf
);
  localparam logic [ADDR_W-1:0] LAST = {ADDR_W{1'b1}};
  state_t state, state_n;
  logic [ADDR_W-1:0] i, i2;
  logic [DATA_W-1:0] s0, s1;
  logic [DATA_W:0] sum;
  add_w #(.W(DATA_W)) u_add (.x(rd0), .y(rd1), .s(sum));
  assign i2 = i + ADDR_W'(2);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end
  always_comb begin
    state_n = state == IDLE  ? (start ? SEED0 : IDLE) :
              state == SEED0 ? SEED1 :
              state == SEED1 ? STEP :
              state == STEP  ? (i2 == LAST ? FIN : STEP) : IDLE;
  end
  always_comb begin
    ra0  = state == STEP ? i : '0;
    ra1  = state == STEP ? i + ADDR_W'(1) : ADDR_W'(1);
    we   = state inside {SEED0, SEED1, STEP};
    busy = we;
    done = state == FIN;
    wa   = state == SEED1 ? ADDR_W'(1) : state == STEP ? i2 : '0;
    wd   = state == SEED0 ? s0 : state == SEED1 ? s1 : state == STEP ? sum[DATA_W-1:0] : '0;
  end
  // Operands are captured from the combinational read, so a/b/c trail the STEP cycle by one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a     <= '0;
      b     <= '0;
      c     <= '0;
      valid <= 1'b0;
      ovf   <= 1'b0;
      i     <= '0;
      s0    <= '0;
      s1    <= '0;
    end else begin
      valid <= state == STEP;
      if (state == IDLE && start) begin
        s0  <= seed0;
        s1  <= seed1;
        ovf <= 1'b0;
        i   <= '0;
      end
      if (state == STEP) begin
        a   <= rd0;
        b   <= rd1;
        c   <= sum[DATA_W-1:0];
        ovf <= ovf | sum[DATA_W];
        if (i2 != LAST) i <= i + ADDR_W'(1);
      end
    end
  end
endmodule

// File: tb/tb_reg_fib_seq.sv
// tb_reg_fib_seq: directed runs against a behavioural register file with a step scoreboard.
module tb_reg_fib_seq;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 1 << AW;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [DW-1:0] seed0 = '0, seed1 = '0;
  logic [AW-1:0] ra0, ra1, wa;
  logic [DW-1:0] rd0, rd1, wd, a, b, c;
  logic we, valid, busy, done, ovf;
  logic [DW-1:0] rf [DEPTH];
  typedef struct packed {logic [DW-1:0] a, b, c;} step_t;
  step_t q[$];
  int tests = 0, fails = 0, n = 0;
  logic exp_ovf;
  always #5 clk = ~clk;
  always @(posedge clk) if (we) rf[wa] <= wd;
  assign rd0 = rf[ra0];
  assign rd1 = rf[ra1];
  reg_fib_seq #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .ra0(ra0), .ra1(ra1), .rd0(rd0), .rd1(rd1), .wa(wa), .wd(wd), .we(we),
    .a(a), .b(b), .c(c), .valid(valid), .busy(busy), .done(done), .ovf(ovf)
  );
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    step_t e;
    @(negedge clk);
    if (valid) begin
      if (q.size() == 0) check("valid_unexpected", 64'(valid), 64'(0));
      else begin
        e = q.pop_front();
        check("a", 64'(a), 64'(e.a));
        check("b", 64'(b), 64'(e.b));
        check("c", 64'(c), 64'(e.c));
      end
    end
  endtask
  task automatic launch(input logic [DW-1:0] s0, input logic [DW-1:0] s1, input bit pulse);
    logic [DW-1:0] x, y;
    logic [DW:0] z;
    x = s0;
    y = s1;
    exp_ovf = 1'b0;
    for (int k = 0; k < DEPTH - 2; k++) begin
      z = {1'b0, x} + {1'b0, y};
      q.push_back({x, y, z[DW-1:0]});
      exp_ovf |= z[DW];
      x = y;
      y = z[DW-1:0];
    end
    seed0 = s0;
    seed1 = s1;
    if (pulse) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    n = 1;
  endtask
  task automatic finish_run(input int pulse_at);
    while (!done && n < 100) begin
      if (n == pulse_at) begin
        start = 1'b1;
        seed0 = 32'h55;
      end
      tick();
      start = 1'b0;
      n++;
    end
    check("done_latency", 64'(n), 64'(DEPTH + 1));
    check("queue_drained", 64'(q.size()), 64'(0));
    check("ovf", 64'(ovf), 64'(exp_ovf));
  endtask
  initial begin
    @(negedge clk);
    check("rst_ra0", 64'(ra0), 64'(0));
    check("rst_ra1", 64'(ra1), 64'(1));
    check("rst_we", 64'(we), 64'(0));
    check("rst_wa", 64'(wa), 64'(0));
    check("rst_wd", 64'(wd), 64'(0));
    check("rst_abc", 64'({a, b} | 64'(c)), 64'(0));
    check("rst_flags", 64'({valid, busy, done, ovf}), 64'(0));
    rst = 1'b0;
    tick();
    launch(32'd1, 32'd1, 1'b1);
    check("busy_run", 64'(busy), 64'(1));
    finish_run(-1);
    tick();
    check("reg31_fib", 64'(rf[31]), 64'(2178309));
    launch(32'h8000_0000, 32'h8000_0000, 1'b1);
    check("ovf_cleared", 64'(ovf), 64'(0));
    finish_run(-1);
    check("ovf_sticky", 64'(ovf), 64'(1));
    tick();
    launch(32'd0, 32'd0, 1'b1);
    finish_run(-1);
    tick();
    for (int k = 0; k < DEPTH; k++) check($sformatf("zero_reg%0d", k), 64'(rf[k]), 64'(0));
    launch(32'd1, 32'd2, 1'b1);
    finish_run(10);
    launch(32'd3, 32'd4, 1'b0);
    start = 1'b1;
    tick();
    check("fin_start_ignored", 64'(busy), 64'(0));
    tick();
    start = 1'b0;
    check("idle_start_taken", 64'(busy), 64'(1));
    finish_run(-1);
    tick();
    launch(32'd1, 32'd1, 1'b1);
    while (n < 13) begin
      tick();
      n++;
    end
    rst = 1'b1;
    #1;
    check("mid_rst_we", 64'(we), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    check("mid_rst_abc", 64'({a, b} | 64'(c)), 64'(0));
    check("mid_rst_ra1", 64'(ra1), 64'(1));
    q.delete();
    tick();
    rst = 1'b0;
    tick();
    launch(32'd2, 32'd3, 1'b1);
    check("first_exp_c", 64'(q[0].c), 64'(5));
    finish_run(-1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
